fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Parametrised read-side controller for the dual-clock FIFO, living entirely in the read clock domain. It consumes the already-synchronized write pointer and advances a wrap-bit read pointer over a memory of arbitrary (non-power-of-two) depth. It drives the memory read address and generates empty, almost-empty, fill count, read-data-valid and sticky underflow status.

## Interface
Parameters:
- ADDRSIZE, 8, pointer width: MSB is the wrap bit, low ADDRSIZE-1 bits are the index.
- DEPTH, 90, number of memory words; 2 ≤ DEPTH ≤ 2^(ADDRSIZE-1).
- ALMOST_EMPTY, 4, almost-empty threshold in words; 0 ≤ ALMOST_EMPTY < DEPTH.

Ports:
- rd_clk  in  1  read-domain clock; the only clock.
- rd_rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request.
- wptr  in  ADDRSIZE  write pointer {wrap, index}, already synchronized into rd_clk.
- uflow_clr  in  1  synchronous clear for runderflow.
- rptr  out  ADDRSIZE  read pointer {wrap, index}, registered.
- raddr  out  ADDRSIZE-1  memory read address, equal to rptr index.
- rempty  out  1  FIFO empty, combinational.
- ralmost_empty  out  1  rcount ≤ ALMOST_EMPTY, combinational.
- rcount  out  ADDRSIZE  words available, 0..DEPTH, combinational.
- rvalid  out  1  memory read data valid, registered.
- runderflow  out  1  sticky underflow flag, registered.

## Operation
- Accepted read: rd_en && !rempty. Only an accepted read advances rptr.
- Pointer advance:
  - index < DEPTH-1: index+1, wrap bit held.
  - index == DEPTH-1: index → 0, wrap bit toggles.
- rempty = (wptr == rptr), comparing all ADDRSIZE bits.
- rcount:
  - Wrap bits equal: w_idx − r_idx.
  - Wrap bits differ: DEPTH − r_idx + w_idx.
  - Computed at ADDRSIZE+1 bits internally, result fits ADDRSIZE. rcount = DEPTH when wrap bits differ and indices are equal.
- ralmost_empty is asserted whenever rempty is asserted. With ALMOST_EMPTY = 0, ralmost_empty equals rempty.
- Underflow:
  - rd_en && rempty sets runderflow on the next edge.
  - rptr does not move and rvalid stays low.
  - uflow_clr clears runderflow. If a set and a clear land on the same cycle, set wins.
- wptr index ≥ DEPTH is illegal. Behaviour is undefined; the bench flags it with an assertion.

## Timing
- Reset values (asynchronous): rptr = 0, raddr = 0, rvalid = 0, runderflow = 0. rempty, ralmost_empty and rcount follow combinationally from wptr with rptr = 0.
- Memory read latency is 1 cycle. raddr is presented in cycle N with an accepted read; the data is valid with rvalid = 1 in cycle N+1.
- rptr and raddr update on the same edge that samples the accepted read.
- Back-to-back reads are sustained at one per cycle until rempty.
- The flags reflect the new rptr immediately after the edge. A read of the last word drops rempty's complement the same cycle; no further read is accepted.
- wptr changes propagate to rempty, rcount and ralmost_empty with zero added latency; synchronizer latency is external to this block.
- Reset mid-operation: rptr returns to 0 and rvalid drops immediately, without waiting for a clock. An in-flight read's data is discarded.

## Structure
- Shared package/include `fifo_pkg` holds:
  - pointer-distance function (wrap-aware count);
  - pointer-increment function (wrap at DEPTH-1);
  - parameter legality checks (DEPTH range, ALMOST_EMPTY < DEPTH).
- One sub-module: `fifo_ptr_cnt`, a wrap-bit pointer counter with async reset and enable. The write-side controller reuses it.
- This block instantiates `fifo_ptr_cnt` and adds the flag, count, valid and sticky logic.

## Test plan
All scenarios use ADDRSIZE = 8, DEPTH = 90, ALMOST_EMPTY = 4.
- Reset with wptr = 0x00:
  - rptr = 0x00, rempty = 1, rcount = 0, ralmost_empty = 1, rvalid = 0, runderflow = 0.
- Streaming reads, wptr = 0x0A:
  - rd_en held 10 cycles → rptr steps 0x01..0x0A, rvalid high cycles 2..11.
  - rempty = 1 after the 10th read; the 11th request sets runderflow.
- Wrap:
  - rptr = 0x59 (index 89), wptr = 0x82, one read → rptr = 0x80, raddr = 0x00, rcount = 2, ralmost_empty = 1.
- Full-level count:
  - rptr = 0x00, wptr = 0x80 → rcount = 90, rempty = 0, ralmost_empty = 0.
  - wptr = 0x05 → rcount = 5, ralmost_empty = 0.
  - wptr = 0x04 → rcount = 4, ralmost_empty = 1.
- Underflow and sticky clear:
  - rptr = wptr = 0x05, rd_en = 1 → rptr stays 0x05, rvalid = 0, runderflow = 1 next cycle.
  - uflow_clr and rd_en together while empty → runderflow stays 1.
  - uflow_clr alone → runderflow = 0.
- Async reset mid-stream:
  - Assert rd_rst between edges during reads at rptr = 0x8C → rptr = 0x00 and rvalid = 0 before the next edge.
  - Reads resume correctly after rd_rst is released.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: wrap-aware pointer
// increment, pointer distance and parameter legality.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;
  typedef logic [PTR_MAX_W:0]   cnt_wide_t;

  // Pointers are {wrap, index}; the index runs 0..depth-1 and the wrap bit
  // toggles each time the index rolls over, so depth need not be a power of two.
  function automatic ptr_wide_t ptr_incr(input ptr_wide_t ptr,
                                         input int unsigned addrsize,
                                         input int unsigned depth);
    ptr_wide_t wrap_bit;
    ptr_wide_t idx;
    wrap_bit = ptr_wide_t'(1) << (addrsize - 1);
    idx      = ptr & (wrap_bit - ptr_wide_t'(1));
    if (idx == ptr_wide_t'(depth - 1))
      return (ptr & wrap_bit) ^ wrap_bit;
    return ptr + ptr_wide_t'(1);
  endfunction

  function automatic cnt_wide_t ptr_dist(input ptr_wide_t wptr,
                                         input ptr_wide_t rptr,
                                         input int unsigned addrsize,
                                         input int unsigned depth);
    ptr_wide_t wrap_bit;
    cnt_wide_t w_idx;
    cnt_wide_t r_idx;
    wrap_bit = ptr_wide_t'(1) << (addrsize - 1);
    w_idx    = {1'b0, wptr & (wrap_bit - ptr_wide_t'(1))};
    r_idx    = {1'b0, rptr & (wrap_bit - ptr_wide_t'(1))};
    if ((wptr & wrap_bit) == (rptr & wrap_bit))
      return w_idx - r_idx;
    return cnt_wide_t'(depth) - r_idx + w_idx;
  endfunction

  function automatic bit params_legal(input int unsigned addrsize,
                                      input int unsigned depth,
                                      input int unsigned almost_empty);
    if (addrsize < 2 || addrsize > PTR_MAX_W) return 1'b0;
    if (depth < 2 || depth > (32'd1 << (addrsize - 1))) return 1'b0;
    if (almost_empty >= depth) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer counter for a FIFO of arbitrary depth; shared by the
// read and write controllers.
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 8,
  parameter int DEPTH    = 90
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [ADDRSIZE-1:0] ptr
);

  logic [ADDRSIZE-1:0] ptr_reg;
  logic [ADDRSIZE-1:0] ptr_next;
  ptr_wide_t           ptr_wide;
  ptr_wide_t           incr_wide;

  assign ptr_wide  = ptr_wide_t'(ptr_reg);
  assign incr_wide = ptr_incr(ptr_wide, ADDRSIZE, DEPTH);
  assign ptr_next  = en ? incr_wide[ADDRSIZE-1:0] : ptr_reg;

  generate
    if (ADDRSIZE < PTR_MAX_W) begin : g_unused_hi
      logic unused_incr_hi;
      assign unused_incr_hi = ^incr_wide[PTR_MAX_W-1:ADDRSIZE];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: advances the read pointer and
// derives empty/almost-empty/count, read-data-valid and sticky underflow.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 8,
  parameter int DEPTH        = 90,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_en,
  input  logic [ADDRSIZE-1:0] wptr,
  input  logic                uflow_clr,
  output logic [ADDRSIZE-1:0] rptr,
  output logic [ADDRSIZE-2:0] raddr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE-1:0] rcount,
  output logic                rvalid,
  output logic                runderflow
);

  generate
    if (!params_legal(ADDRSIZE, DEPTH, ALMOST_EMPTY)) begin : g_bad_params
      $error("fifo_read_ctrl: illegal ADDRSIZE/DEPTH/ALMOST_EMPTY combination");
    end
  endgenerate

  logic                rd_accept;
  logic                rd_reject;
  logic [ADDRSIZE-1:0] rptr_cur;
  cnt_wide_t           dist_wide;
  logic                rvalid_reg;
  logic                runderflow_reg;

  fifo_ptr_cnt #(
    .ADDRSIZE (ADDRSIZE),
    .DEPTH    (DEPTH)
  ) u_rptr (
    .clk (rd_clk),
    .rst (rd_rst),
    .en  (rd_accept),
    .ptr (rptr_cur)
  );

  // Flags are purely combinational so a new wptr is visible the same cycle.
  assign rempty        = (wptr == rptr_cur);
  assign dist_wide     = ptr_dist(ptr_wide_t'(wptr), ptr_wide_t'(rptr_cur), ADDRSIZE, DEPTH);
  assign rcount        = dist_wide[ADDRSIZE-1:0];
  assign ralmost_empty = (rcount <= ADDRSIZE'(ALMOST_EMPTY));

  generate
    if (ADDRSIZE < PTR_MAX_W + 1) begin : g_unused_dist
      logic unused_dist_hi;
      assign unused_dist_hi = ^dist_wide[PTR_MAX_W:ADDRSIZE];
    end
  endgenerate

  assign rd_accept = rd_en && !rempty;
  assign rd_reject = rd_en && rempty;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rvalid_reg     <= 1'b0;
      runderflow_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd_accept;
      // Set has priority over a same-cycle clear.
      if (rd_reject)      runderflow_reg <= 1'b1;
      else if (uflow_clr) runderflow_reg <= 1'b0;
    end
  end

  assign rptr       = rptr_cur;
  assign raddr      = rptr_cur[ADDRSIZE-2:0];
  assign rvalid     = rvalid_reg;
  assign runderflow = runderflow_reg;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized self-checking bench for fifo_read_ctrl against a position-based
// reference model (pointers as positions on a ring of 2*DEPTH).
module tb_fifo_read_ctrl;

  localparam int ADDRSIZE     = 8;
  localparam int DEPTH        = 90;
  localparam int ALMOST_EMPTY = 4;
  localparam int RING         = 2 * DEPTH;

  logic                rd_clk = 1'b0;
  logic                rd_rst = 1'b1;
  logic                rd_en = 1'b0;
  logic [ADDRSIZE-1:0] wptr = '0;
  logic                uflow_clr = 1'b0;
  logic [ADDRSIZE-1:0] rptr;
  logic [ADDRSIZE-2:0] raddr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE-1:0] rcount;
  logic                rvalid;
  logic                runderflow;

  fifo_read_ctrl #(
    .ADDRSIZE     (ADDRSIZE),
    .DEPTH        (DEPTH),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .rd_en         (rd_en),
    .wptr          (wptr),
    .uflow_clr     (uflow_clr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .rvalid        (rvalid),
    .runderflow    (runderflow)
  );

  always #5 rd_clk = ~rd_clk;

  // A write-pointer index at or beyond DEPTH is never legal.
  always @(negedge rd_clk) begin
    if (!rd_rst)
      assert (int'(wptr[ADDRSIZE-2:0]) < DEPTH) else $error("illegal wptr index %0h", wptr);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  int m_rpos = 0;
  int m_wpos = 0;
  bit m_valid = 1'b0;
  bit m_uflow = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int enc(input int p);
    return ((p >= DEPTH) ? (1 << (ADDRSIZE - 1)) : 0) + (p % DEPTH);
  endfunction

  function automatic int fill(input int w, input int r);
    return (w - r + RING) % RING;
  endfunction

  task automatic check_flags();
    int c;
    c = fill(m_wpos, m_rpos);
    chk("rptr",          32'(rptr),          32'(enc(m_rpos)));
    chk("raddr",         32'(raddr),         32'(m_rpos % DEPTH));
    chk("rcount",        32'(rcount),        32'(c));
    chk("rempty",        32'(rempty),        32'(c == 0));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(c <= ALMOST_EMPTY));
  endtask

  // One clock transaction: drive at negedge, check flags, model the edge,
  // then check registered outputs just after it.
  task automatic step(input bit en, input int wpos, input bit clr);
    int c;
    @(negedge rd_clk);
    rd_en     = en;
    m_wpos    = wpos % RING;
    wptr      = ADDRSIZE'(enc(m_wpos));
    uflow_clr = clr;
    #1;
    check_flags();
    c = fill(m_wpos, m_rpos);
    @(posedge rd_clk);
    m_valid = en && (c != 0);
    if (m_valid) m_rpos = (m_rpos + 1) % RING;
    if (en && c == 0) m_uflow = 1'b1;
    else if (clr)     m_uflow = 1'b0;
    #1;
    chk("rptr_post",  32'(rptr),       32'(enc(m_rpos)));
    chk("rvalid",     32'(rvalid),     32'(m_valid));
    chk("runderflow", 32'(runderflow), 32'(m_uflow));
    n_step++;
    $display("step %0d en=%0b wptr=%02h clr=%0b -> rptr=%02h rcount=%0d rvalid=%0b uflow=%0b",
             n_step, en, wptr, clr, rptr, rcount, rvalid, runderflow);
  endtask

  task automatic do_reset(input int wpos);
    @(negedge rd_clk);
    rd_rst = 1'b1;
    rd_en  = 1'b0;
    uflow_clr = 1'b0;
    m_wpos = wpos % RING;
    wptr   = ADDRSIZE'(enc(m_wpos));
    m_rpos = 0;
    m_valid = 1'b0;
    m_uflow = 1'b0;
    #1;
    check_flags();
    chk("rst_rvalid",     32'(rvalid),     32'(0));
    chk("rst_runderflow", 32'(runderflow), 32'(0));
    @(negedge rd_clk);
    rd_rst = 1'b0;
    $display("reset wptr=%02h", wptr);
  endtask

  initial begin
    int k;
    int c;

    // Reset state with an empty FIFO.
    do_reset(0);

    // Streaming: 10 words, 11 requests; the last one underflows.
    for (int i = 0; i < 11; i++) step(1'b1, 10, 1'b0);
    step(1'b0, 10, 1'b1);

    // Advance to index 89 then read across the wrap with wptr = 0x82.
    for (int i = 0; i < 79; i++) step(1'b1, DEPTH, 1'b0);
    chk("pre_wrap_rptr", 32'(rptr), 32'h59);
    step(1'b1, DEPTH + 2, 1'b0);
    chk("wrap_rptr", 32'(rptr), 32'h80);
    step(1'b0, DEPTH + 2, 1'b0);

    // Full-level count and almost-empty threshold.
    do_reset(DEPTH);
    step(1'b0, DEPTH, 1'b0);
    step(1'b0, 5, 1'b0);
    step(1'b0, 4, 1'b0);

    // Underflow at rptr = wptr = 0x05, sticky through a simultaneous clear.
    for (int i = 0; i < 5; i++) step(1'b1, 5, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 5, 1'b1);
    chk("uflow_sticky", 32'(runderflow), 32'(1));
    step(1'b0, 5, 1'b1);
    chk("uflow_clear", 32'(runderflow), 32'(0));

    // Randomized traffic with a writer that keeps the fill level legal.
    for (int i = 0; i < 300; i++) begin
      c = fill(m_wpos, m_rpos);
      k = (($urandom_range(0, 15) == 0) ? int'($urandom_range(0, DEPTH)) : int'($urandom_range(0, 2)));
      if (c + k > DEPTH) k = DEPTH - c;
      step(1'($urandom_range(0, 3) != 0), m_wpos + k, 1'($urandom_range(0, 7) == 0));
    end

    // Async reset while streaming at rptr = 0x8C.
    do_reset(50);
    while (m_rpos != DEPTH + 12) step(1'b1, m_rpos + 50, 1'b0);
    chk("pre_rst_rptr", 32'(rptr), 32'h8C);
    @(negedge rd_clk);
    rd_en  = 1'b1;
    m_wpos = (m_rpos + 50) % RING;
    wptr   = ADDRSIZE'(enc(m_wpos));
    @(posedge rd_clk);
    #2;
    chk("midrst_rvalid_before", 32'(rvalid), 32'(1));
    rd_rst = 1'b1;
    #1;
    chk("midrst_rptr",   32'(rptr),   32'(0));
    chk("midrst_rvalid", 32'(rvalid), 32'(0));
    $display("async reset mid-stream rptr=%02h rvalid=%0b", rptr, rvalid);
    rd_en   = 1'b0;
    m_rpos  = 0;
    m_valid = 1'b0;
    m_uflow = 1'b0;
    m_wpos  = 20;
    wptr    = ADDRSIZE'(enc(m_wpos));
    @(negedge rd_clk);
    rd_rst = 1'b0;
    for (int i = 0; i < 22; i++) step(1'b1, 20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
